// File: rtl/addsub_arbiter_if.sv
// Request/response bundle between N requesters and the shared add/subtract unit.
// Requester i owns lane [i*WIDTH +: WIDTH] of req_a/req_b and bit i of the other vectors.
interface addsub_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*WIDTH-1:0] req_a;
  logic [N*WIDTH-1:0] req_b;
  logic [N-1:0]       req_op;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [WIDTH-1:0]   rsp_diff;
  logic               rsp_c;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_diff, rsp_c
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_diff, rsp_c
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit carry-chain adder/subtractor among N requesters.
// One operation in flight: IDLE (grant) -> CALC (adder) -> RESP (hold until accepted).
module addsub_arbiter #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  addsub_arbiter_if.slave   bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             op_q;
  logic [IDW-1:0]   id_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_diff_q;
  logic             rsp_c_q;

  logic [N-1:0][WIDTH-1:0] a_arr, b_arr;
  logic [N-1:0]            gnt;
  logic [IDW-1:0]          win;
  logic                    found;
  int                      idx;
  logic [WIDTH-1:0]        b_eff;
  logic [WIDTH:0]          sum;

  assign a_arr = bus.req_a;
  assign b_arr = bus.req_b;

  // Walk from the farthest candidate back to ptr so the nearest valid one wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (bus.req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt     = '0;
    case (state_q)
      IDLE: if (found) begin
        gnt[win] = 1'b1;
        ptr_d    = (win == IDW'(N - 1)) ? '0 : win + 1'b1;
        state_d  = CALC;
      end
      CALC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtract is A + ~B + 1, so carry-out doubles as the unsigned A >= B flag.
  assign b_eff = op_q ? b_q : ~b_q;
  assign sum   = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ~op_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_diff_q  <= '0;
      rsp_c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      case (state_q)
        IDLE: if (found) begin
          a_q  <= a_arr[win];
          b_q  <= b_arr[win];
          op_q <= bus.req_op[win];
          id_q <= win;
        end
        CALC: begin
          rsp_diff_q  <= sum[WIDTH-1:0];
          rsp_c_q     <= sum[WIDTH];
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
        end
        RESP: if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.req_ready = rst_i ? '0 : gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_diff  = rsp_diff_q;
  assign bus.rsp_c     = rsp_c_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: expected responses are queued at drive time
// and popped when the response registers go valid.
module tb_addsub_arbiter;
  localparam int WIDTH = 8;
  localparam int N     = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] diff;
    logic       c;
  } exp_t;

  logic clk, rst;
  int   cyc = 0;
  int   checks = 0, failures = 0;
  exp_t q[$];

  addsub_arbiter_if #(.WIDTH(WIDTH), .N(N)) bus();

  addsub_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int id, input logic [7:0] a, input logic [7:0] b, input logic op);
    exp_t r;
    logic [8:0] s;
    r.id = 2'(id);
    if (op) begin
      s      = {1'b0, a} + {1'b0, b};
      r.diff = s[7:0];
      r.c    = s[8];
    end else begin
      r.diff = a - b;
      r.c    = (a >= b);
    end
    return r;
  endfunction

  task automatic drive(input int id, input logic [7:0] a, input logic [7:0] b, input logic op, input bit push);
    bus.req_valid[id]       = 1'b1;
    bus.req_a[id*WIDTH +: WIDTH] = a;
    bus.req_b[id*WIDTH +: WIDTH] = b;
    bus.req_op[id]          = op;
    if (push) q.push_back(model(id, a, b, op));
  endtask

  task automatic wait_grant(input logic [3:0] exp, input string tag, output int gcyc);
    int n = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.req_ready), 32'(exp));
    gcyc = cyc;
  endtask

  task automatic wait_rsp(input string tag, output int rcyc, output exp_t e);
    int n = 0;
    e = '0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    rcyc = cyc;
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    if (q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_id"},   32'(bus.rsp_id),   32'(e.id));
      chk({tag, "_diff"}, 32'(bus.rsp_diff), 32'(e.diff));
      chk({tag, "_c"},    32'(bus.rsp_c),    32'(e.c));
    end
  endtask

  task automatic single(input int id, input logic [7:0] a, input logic [7:0] b, input logic op, input string tag);
    int gc, rc;
    exp_t e;
    @(posedge clk); #1;
    drive(id, a, b, op, 1'b1);
    wait_grant(4'(1 << id), {tag, "_gnt"}, gc);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(tag, rc, e);
  endtask

  initial begin
    int k0, gc, rc, prev;
    exp_t e;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.req_valid = 4'b1111;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("rst_rsp_diff",  32'(bus.rsp_diff),  32'd0);
    chk("rst_rsp_c",     32'(bus.rsp_c),     32'd0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    rst = 1'b0;

    // Compare A > B with response latency measured from the drive cycle.
    @(posedge clk); #1;
    k0 = cyc;
    drive(0, 8'h05, 8'h03, 1'b0, 1'b1);
    wait_grant(4'b0001, "cmp_gt_gnt", gc);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp("cmp_gt", rc, e);
    chk("cmp_gt_latency", 32'(rc - k0), 32'd2);

    single(2, 8'h03, 8'h05, 1'b0, "cmp_borrow");
    single(3, 8'h80, 8'h80, 1'b0, "cmp_equal");
    single(1, 8'hFF, 8'h01, 1'b1, "add_wrap");
    single(3, 8'h7F, 8'h01, 1'b1, "add_nowrap");

    // Fairness: everybody valid, PTR is back at 0.
    @(posedge clk); #1;
    drive(0, 8'h11, 8'h01, 1'b0, 1'b1);
    drive(1, 8'h22, 8'h02, 1'b1, 1'b1);
    drive(2, 8'h33, 8'h43, 1'b0, 1'b1);
    drive(3, 8'hF4, 8'h14, 1'b1, 1'b1);
    q.push_back(model(0, 8'h11, 8'h01, 1'b0));
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(4'(1 << (g % 4)), "fair_gnt", gc);
      if (g > 0) chk("fair_gap", 32'(gc - prev), 32'd3);
      prev = gc;
      @(posedge clk); #1;
      if (g == 4) bus.req_valid = '0;
      wait_rsp("fair", rc, e);
    end

    // Back-pressure: hold the response for 5 RESP cycles with another request pending.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    drive(2, 8'h10, 8'h20, 1'b1, 1'b1);
    wait_grant(4'b0100, "bp_gnt", gc);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp("bp", rc, e);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) begin
        @(posedge clk); #1;
        drive(0, 8'h40, 8'h41, 1'b0, 1'b1);
        @(negedge clk);
      end
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_id",    32'(bus.rsp_id),    32'(e.id));
      chk("bp_hold_diff",  32'(bus.rsp_diff),  32'(e.diff));
      chk("bp_hold_c",     32'(bus.rsp_c),     32'(e.c));
      chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    k0 = cyc;
    @(negedge clk);
    chk("bp_same_cycle_ready", 32'(bus.req_ready), 32'd0);
    wait_grant(4'b0001, "bp_next_gnt", gc);
    chk("bp_rsp_cleared", 32'(bus.rsp_valid), 32'd0);
    chk("bp_gnt_cycle", 32'(gc - k0), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp("bp_next", rc, e);

    // Reset during CALC of a req 3 operation discards it.
    @(posedge clk); #1;
    drive(3, 8'h09, 8'h04, 1'b0, 1'b0);
    wait_grant(4'b1000, "rst_op_gnt", gc);
    @(posedge clk); #1;
    bus.req_valid = '0;
    #1 rst = 1'b1;
    drive(1, 8'h0A, 8'h0B, 1'b1, 1'b1);
    drive(3, 8'hC0, 8'h30, 1'b0, 1'b1);
    #1;
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("midrst_rsp_diff",  32'(bus.rsp_diff),  32'd0);
    chk("midrst_rsp_c",     32'(bus.rsp_c),     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_grant(4'b0010, "postrst_ptr0", gc);
    chk("postrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    wait_rsp("postrst_r1", rc, e);
    wait_grant(4'b1000, "postrst_r3_gnt", gc);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp("postrst_r3", rc, e);

    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
